kypd_scanner: RTL and testbench

Matrix-keypad scanner for a 4x4 Pmod keypad: drives one row low at a time, samples the columns, debounces whole-matrix snapshots and delivers single-key press events over a valid/ack handshake. It is the input-side counterpart of the multiplexed display driver. That driver scans anodes outward; this block scans rows and reads columns inward. It sits beside the debounced front-panel buttons and feeds key codes to the clock-setting logic.

---
 rtl/kypd_scanner.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_kypd_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_scanner.sv
// kypd_scanner -- 4x4 matrix keypad scanner with debounce and event handshake.
//
// Drives one row low at a time and holds it for SCAN_COUNT cycles. The
// synchronized columns are sampled on the last cycle of each row. After all
// four rows are sampled, the 16-bit snapshot is classified as NONE, SINGLE(k)
// or MULTI. A small FSM debounces presses and releases over DEB_SCANS scans
// and emits one key event per accepted press.
//
// Optional feature: define KYPD_REPEAT_EN to enable auto-repeat. The first
// re-emit comes after 128 matching scans, then one every 32 scans. Without
// the macro no repeat counter exists.
//
// Handshake: key_valid_o rises when an event is loaded and stays high until
// key_ack_i is sampled high. key_code_o is stable while key_valid_o is high.
// An event that arrives while valid is high and no ack is present is dropped,
// and overrun_o pulses for one cycle. If ack and a new event arrive in the
// same cycle, the new event is loaded and valid stays high.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   col_i[3:0]   keypad columns, active-low, asynchronous
//   row_o[3:0]   keypad rows, active-low, one bit low at a time
//   key_valid_o  event pending
//   key_code_o   hex code of the pending key
//   key_ack_i    consumer acknowledge
//   key_held_o   a debounced key is currently down
//   overrun_o    one-cycle pulse for each dropped event
//   state_dbg    current debounce FSM state (0 idle, 1 debounce, 2 pressed, 3 release)

module kypd_scanner #(
    parameter int SCAN_COUNT = 50000,
    parameter int DEB_SCANS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    input  logic       key_ack_i,
    output logic       key_held_o,
    output logic       overrun_o,
    output logic [1:0] state_dbg
);

    localparam int            CW     = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_COUNT - 1);
    localparam logic [3:0]    DEB    = 4'(DEB_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} class_t;

    logic [3:0]    col_s1, col_s2;
    logic [1:0]    r;
    logic [CW-1:0] c;
    logic [15:0]   snap;
    state_t        state, state_nxt;
    logic [3:0]    n, n_nxt;
    logic [3:0]    cand, cand_nxt;
    logic          valid;
    logic [3:0]    code;
    logic          ovr;

    logic          sample, done;
    logic [15:0]   full;
    class_t        cls;
    logic [3:0]    idx;
    logic [3:0]    key;
    logic          emit;
    logic [3:0]    emit_code;
    logic [3:0]    n_inc;

`ifdef KYPD_REPEAT_EN
    logic [7:0]    rpt, rpt_nxt;
`endif

    // Map a snapshot bit index (4*row + column) to the printed key value.
    function automatic logic [3:0] key_of(input logic [3:0] i);
        case (i)
            4'd0:    key_of = 4'h1;
            4'd1:    key_of = 4'h2;
            4'd2:    key_of = 4'h3;
            4'd3:    key_of = 4'hA;
            4'd4:    key_of = 4'h4;
            4'd5:    key_of = 4'h5;
            4'd6:    key_of = 4'h6;
            4'd7:    key_of = 4'hB;
            4'd8:    key_of = 4'h7;
            4'd9:    key_of = 4'h8;
            4'd10:   key_of = 4'h9;
            4'd11:   key_of = 4'hC;
            4'd12:   key_of = 4'h0;
            4'd13:   key_of = 4'hF;
            4'd14:   key_of = 4'hE;
            default: key_of = 4'hD;
        endcase
    endfunction

    assign row_o       = ~(4'b0001 << r);
    assign key_valid_o = valid;
    assign key_code_o  = code;
    assign overrun_o   = ovr;
    assign key_held_o  = (state == PRESSED) || (state == RELEASE);
    assign state_dbg   = state;

    assign sample = (c == C_LAST);
    assign done   = sample && (r == 2'd3);
    // Row 3 is still being written on the completing cycle, so classify the
    // snapshot with the live synchronized columns in its place.
    assign full   = {col_s2, snap[11:0]};
    assign key    = key_of(idx);
    assign n_inc  = n + 4'd1;

    // Column synchronizer, row/cycle counters and snapshot capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
            r      <= 2'd0;
            c      <= '0;
            snap   <= 16'hFFFF;
        end else begin
            col_s1 <= col_i;
            col_s2 <= col_s1;
            if (sample) begin
                c                   <= '0;
                r                   <= r + 2'd1;
                snap[{r, 2'b00} +: 4] <= col_s2;
            end else begin
                c <= c + CW'(1);
            end
        end
    end

    // Classify the completed snapshot; a column reads low when its key is down.
    always_comb begin
        cls = CLS_NONE;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!full[i]) begin
                if (cls == CLS_NONE) begin
                    cls = CLS_SINGLE;
                    idx = 4'(i);
                end else begin
                    cls = CLS_MULTI;
                end
            end
        end
    end

    // Debounce FSM, state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            n     <= 4'd0;
            cand  <= 4'd0;
`ifdef KYPD_REPEAT_EN
            rpt   <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            cand  <= cand_nxt;
`ifdef KYPD_REPEAT_EN
            rpt   <= rpt_nxt;
`endif
        end
    end

    // Debounce FSM, next state and emit decision (acts only on scan complete).
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        cand_nxt  = cand;
        emit      = 1'b0;
        emit_code = cand;
`ifdef KYPD_REPEAT_EN
        rpt_nxt   = rpt;
`endif
        if (done) begin
            case (state)
                IDLE: begin
                    if (cls == CLS_SINGLE) begin
                        cand_nxt  = key;
                        n_nxt     = 4'd1;
                        emit_code = key;
                        if (DEB == 4'd1) begin
                            emit      = 1'b1;
                            state_nxt = PRESSED;
`ifdef KYPD_REPEAT_EN
                            rpt_nxt   = 8'd0;
`endif
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cls == CLS_SINGLE && key == cand) begin
                        n_nxt = n_inc;
                        if (n_inc == DEB) begin
                            emit      = 1'b1;
                            state_nxt = PRESSED;
`ifdef KYPD_REPEAT_EN
                            rpt_nxt   = 8'd0;
`endif
                        end
                    end else if (cls == CLS_SINGLE) begin
                        cand_nxt = key;
                        n_nxt    = 4'd1;
                    end else begin
                        n_nxt     = 4'd0;
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (cls == CLS_NONE) begin
`ifdef KYPD_REPEAT_EN
                        rpt_nxt = 8'd0;
`endif
                        if (DEB == 4'd1) begin
                            n_nxt     = 4'd0;
                            state_nxt = IDLE;
                        end else begin
                            n_nxt     = 4'd1;
                            state_nxt = RELEASE;
                        end
                    end
`ifdef KYPD_REPEAT_EN
                    else if (cls == CLS_SINGLE && key == cand) begin
                        // 128th matching scan fires the first repeat; reloading
                        // 96 makes every following repeat 32 scans apart.
                        if (rpt == 8'd127) begin
                            emit    = 1'b1;
                            rpt_nxt = 8'd96;
                        end else begin
                            rpt_nxt = rpt + 8'd1;
                        end
                    end else begin
                        rpt_nxt = 8'd0;
                    end
`endif
                end
                RELEASE: begin
                    if (cls == CLS_NONE) begin
                        if (n_inc == DEB) begin
                            n_nxt     = 4'd0;
                            state_nxt = IDLE;
                        end else begin
                            n_nxt = n_inc;
                        end
                    end else begin
                        state_nxt = PRESSED;
`ifdef KYPD_REPEAT_EN
                        rpt_nxt   = 8'd0;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Event handshake. An ack in the same cycle as an emit frees the slot,
    // so the new event loads without an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            code  <= 4'd0;
            ovr   <= 1'b0;
        end else begin
            ovr <= 1'b0;
            if (emit) begin
                if (!valid || key_ack_i) begin
                    code  <= emit_code;
                    valid <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (key_ack_i) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kypd_scanner.sv
module tb_kypd_scanner;
  localparam int SC  = 4;
  localparam int DEB = 2;
  localparam int SCAN_CYC = 4 * SC;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic       key_valid_o;
  logic [3:0] key_code_o;
  logic       key_ack_i;
  logic       key_held_o;
  logic       overrun_o;
  logic [1:0] state_dbg;

  kypd_scanner #(.SCAN_COUNT(SC), .DEB_SCANS(DEB)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .col_i       (col_i),
    .row_o       (row_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .key_ack_i   (key_ack_i),
    .key_held_o  (key_held_o),
    .overrun_o   (overrun_o),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keypad model ----------------
  // pressed[4*row + col] = 1 means that key is physically down.
  logic [15:0] pressed;

  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_o[r]) col_i = col_i & ~pressed[4*r +: 4];
    end
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int n_checks;
  int n_err;
  int ovr_cnt;
  bit auto_ack;
  bit force_ack;
  logic prev_valid;
  logic prev_ack;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; observe outputs #1 after the edge; then drive ack.
  task automatic cycle();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (key_valid_o && (!prev_valid || prev_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(key_code_o), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("event_code", 32'(key_code_o), 32'(e));
      end
    end
    if (overrun_o) ovr_cnt++;
    prev_valid = key_valid_o;
    key_ack_i  = force_ack | (auto_ack & key_valid_o);
    prev_ack   = key_ack_i;
  endtask

  task automatic wait_scans(input int s);
    repeat (s * SCAN_CYC) cycle();
  endtask

  // Return just after the edge that starts a new scan (row 3 -> row 0).
  task automatic align();
    bit found;
    logic [3:0] pr;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      pr = row_o;
      cycle();
      if (pr == 4'b0111 && row_o == 4'b1110) found = 1'b1;
    end
    if (!found) check("align_timeout", 32'(found), 32'd1);
  endtask

  task automatic ack_once();
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();
  endtask

  function automatic logic [15:0] bit_of(input int i);
    logic [15:0] v;
    v = 16'd0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] exp_row;
    int ovr_before;
    pressed    = 16'd0;
    key_ack_i  = 1'b0;
    auto_ack   = 1'b0;
    force_ack  = 1'b0;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    n_checks   = 0;
    n_err      = 0;
    ovr_cnt    = 0;
    rst_n      = 1'b0;

    repeat (3) cycle();
    check("rst_row", 32'(row_o), 32'hE);
    check("rst_valid", 32'(key_valid_o), 32'd0);
    check("rst_code", 32'(key_code_o), 32'd0);
    check("rst_held", 32'(key_held_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Row rotation: each row low for SC cycles, 1110 -> 1101 -> 1011 -> 0111.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cycle();
      exp_row = ~(4'b0001 << (i / SC));
      check("row_rotation", 32'(row_o), 32'(exp_row));
    end
    check("idle_valid", 32'(key_valid_o), 32'd0);

    // Key 6 held 5 scans, no ack until checked.
    align();
    exp_q.push_back(4'h6);
    pressed = bit_of(6);
    wait_scans(5);
    check("k6_valid", 32'(key_valid_o), 32'd1);
    check("k6_code", 32'(key_code_o), 32'h6);
    check("k6_held", 32'(key_held_o), 32'd1);
    ack_once();
    check("k6_ack_clears", 32'(key_valid_o), 32'd0);
    pressed = 16'd0;
    cycle();
    cycle();
    check("k6_held_after_release", 32'(key_held_o), 32'd1);
    wait_scans(3);
    check("k6_released", 32'(key_held_o), 32'd0);
    check("k6_state_idle", 32'(state_dbg), 32'd0);

    // Key 5 bouncing, then stable: one event only.
    auto_ack = 1'b1;
    align();
    for (int b = 0; b < 3; b++) begin
      pressed = bit_of(5);
      wait_scans(1);
      pressed = 16'd0;
      wait_scans(1);
    end
    check("bounce_no_event_yet", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(4'h5);
    pressed = bit_of(5);
    wait_scans(4);
    check("k5_held", 32'(key_held_o), 32'd1);
    check("k5_consumed", 32'(exp_q.size()), 32'd0);
    pressed = 16'd0;
    wait_scans(4);

    // Keys 1 + A together: no event; release A -> event 1.
    auto_ack = 1'b0;
    align();
    pressed = bit_of(0) | bit_of(3);
    wait_scans(4);
    check("multi_no_valid", 32'(key_valid_o), 32'd0);
    check("multi_not_held", 32'(key_held_o), 32'd0);
    exp_q.push_back(4'h1);
    pressed = bit_of(0);
    wait_scans(4);
    check("k1_valid", 32'(key_valid_o), 32'd1);
    check("k1_code", 32'(key_code_o), 32'h1);
    ack_once();
    pressed = 16'd0;
    wait_scans(4);

    // F pending without ack, then D dropped with an overrun.
    ovr_before = ovr_cnt;
    align();
    exp_q.push_back(4'hF);
    pressed = bit_of(13);
    wait_scans(4);
    pressed = 16'd0;
    wait_scans(4);
    align();
    pressed = bit_of(15);
    wait_scans(4);
    check("overrun_code_kept", 32'(key_code_o), 32'hF);
    check("overrun_valid", 32'(key_valid_o), 32'd1);
    check("overrun_pulses", 32'(ovr_cnt - ovr_before), 32'd1);
    pressed = 16'd0;
    wait_scans(4);

    // D again, ack coinciding with the emit edge (end of second scan).
    align();
    exp_q.push_back(4'hD);
    pressed = bit_of(15);
    repeat (2 * SCAN_CYC - 2) cycle();
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();
    check("same_cycle_valid", 32'(key_valid_o), 32'd1);
    check("same_cycle_code", 32'(key_code_o), 32'hD);
    check("same_cycle_no_overrun", 32'(ovr_cnt - ovr_before), 32'd1);
    ack_once();
    check("d_acked", 32'(key_valid_o), 32'd0);
    pressed = 16'd0;
    wait_scans(4);

    // Hold 0 for 200 scans with auto-ack.
    auto_ack = 1'b1;
    align();
`ifdef KYPD_REPEAT_EN
    repeat (4) exp_q.push_back(4'h0);
`else
    exp_q.push_back(4'h0);
`endif
    pressed = bit_of(12);
    wait_scans(200);
    pressed = 16'd0;
    wait_scans(4);
    check("hold0_events_done", 32'(exp_q.size()), 32'd0);
    check("hold0_no_overrun", 32'(ovr_cnt - ovr_before), 32'd1);

    // Reset with an event pending discards it.
    auto_ack = 1'b0;
    align();
    exp_q.push_back(4'h9);
    pressed = bit_of(10);
    wait_scans(4);
    check("k9_valid", 32'(key_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(key_valid_o), 32'd0);
    check("rst_mid_held", 32'(key_held_o), 32'd0);
    check("rst_mid_code", 32'(key_code_o), 32'd0);
    check("rst_mid_row", 32'(row_o), 32'hE);
    pressed = 16'd0;
    cycle();
    rst_n = 1'b1;
    wait_scans(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
